// File: rtl/tank_pkg.sv
// Shared types, default keycodes and the position clamp helper for the tank mover.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_U = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_MOVE,
    ST_BLOCKED
  } tank_state_t;

  localparam logic [7:0] KEY_LEFT_DEF  = 8'd80;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'd79;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'd81;
  localparam logic [7:0] KEY_UP_DEF    = 8'd82;

  // Limits an 11-bit coordinate to [lo, hi] and narrows it to the 10-bit position width.
  function automatic logic [9:0] clamp_pos(input logic [10:0] v,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi);
    if (v < lo)      return 10'(lo);
    else if (v > hi) return 10'(hi);
    else             return 10'(v);
  endfunction

endpackage

// File: rtl/tank_mover_if.sv
// Key/barrier/spawn inputs and position/heading outputs of the tank mover.
interface tank_mover_if;
  logic [7:0] keycode;
  logic       speed_upgrade;
  logic [3:0] barrier_collision;
  logic       spawn_req;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic [1:0] direction;
  logic       moving;
  logic       spawn_ack;

  modport master (
    output keycode, speed_upgrade, barrier_collision, spawn_req, spawn_x, spawn_y,
    input  BallX, BallY, BallS, direction, moving, spawn_ack
  );

  modport slave (
    input  keycode, speed_upgrade, barrier_collision, spawn_req, spawn_x, spawn_y,
    output BallX, BallY, BallS, direction, moving, spawn_ack
  );
endinterface

// File: rtl/tank_step_clamp.sv
// One-frame step of the tank position along a heading, saturating at the arena limits.
module tank_step_clamp
  import tank_pkg::*;
(
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  dir_t        dir_i,
  input  logic [10:0] step_i,
  input  logic [10:0] x_lo_i,
  input  logic [10:0] x_hi_i,
  input  logic [10:0] y_lo_i,
  input  logic [10:0] y_hi_i,
  output logic [9:0]  next_x_o,
  output logic [9:0]  next_y_o,
  output logic        at_edge_o
);
  logic [10:0] px;
  logic [10:0] py;

  // 11-bit arithmetic so neither the add nor the floor compare can wrap.
  always_comb begin
    px        = {1'b0, pos_x_i};
    py        = {1'b0, pos_y_i};
    next_x_o  = pos_x_i;
    next_y_o  = pos_y_i;
    at_edge_o = 1'b0;
    unique case (dir_i)
      DIR_L: begin
        at_edge_o = (px <= x_lo_i);
        next_x_o  = (px < x_lo_i + step_i) ? 10'(x_lo_i) : 10'(px - step_i);
      end
      DIR_R: begin
        at_edge_o = (px >= x_hi_i);
        next_x_o  = (px + step_i > x_hi_i) ? 10'(x_hi_i) : 10'(px + step_i);
      end
      DIR_D: begin
        at_edge_o = (py >= y_hi_i);
        next_y_o  = (py + step_i > y_hi_i) ? 10'(y_hi_i) : 10'(py + step_i);
      end
      DIR_U: begin
        at_edge_o = (py <= y_lo_i);
        next_y_o  = (py < y_lo_i + step_i) ? 10'(y_lo_i) : 10'(py - step_i);
      end
    endcase
  end
endmodule

// File: rtl/tank_mover.sv
// Keyboard-driven tank position controller, one update per frame_clk edge.
// TANK_TURN_DELAY_EN builds the TURN state and its frame counter.
//   state      | meaning
//   ST_IDLE    | no key held, or just respawned
//   ST_TURN    | heading changed, waiting TURN_FRAMES frames before moving
//   ST_MOVE    | stepping along the heading every frame
//   ST_BLOCKED | heading held but barrier or arena edge stops motion
module tank_mover
  import tank_pkg::*;
#(
  parameter int          X_CENTER    = 480,
  parameter int          Y_CENTER    = 240,
  parameter int          X_MIN       = 1,
  parameter int          X_MAX       = 639,
  parameter int          Y_MIN       = 1,
  parameter int          Y_MAX       = 479,
  parameter int          SIZE        = 8,
  parameter int          SPEED_SLOW  = 1,
  parameter int          SPEED_FAST  = 3,
  parameter int          TURN_FRAMES = 4,
  parameter logic [7:0]  KEY_LEFT    = KEY_LEFT_DEF,
  parameter logic [7:0]  KEY_RIGHT   = KEY_RIGHT_DEF,
  parameter logic [7:0]  KEY_DOWN    = KEY_DOWN_DEF,
  parameter logic [7:0]  KEY_UP      = KEY_UP_DEF
) (
  input  logic        frame_clk,
  input  logic        Reset,
  tank_mover_if.slave bus
);
  localparam logic [10:0] X_LO      = 11'(X_MIN + SIZE);
  localparam logic [10:0] X_HI      = 11'(X_MAX - SIZE);
  localparam logic [10:0] Y_LO      = 11'(Y_MIN + SIZE);
  localparam logic [10:0] Y_HI      = 11'(Y_MAX - SIZE);
  localparam logic [3:0]  TURN_LOAD = 4'(TURN_FRAMES - 1);

  tank_state_t state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        moving_q, ack_q;
  logic        key_valid;
  dir_t        key_dir;
  logic [10:0] step;
  logic [9:0]  step_x, step_y;
  logic        at_edge, bar_hit, blocked, attempt;
`ifdef TANK_TURN_DELAY_EN
  logic [3:0]  cnt_q, cnt_d;
`else
  logic        unused_turn_cfg;
  assign unused_turn_cfg = ^TURN_LOAD;
`endif

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_L;
    if (bus.keycode == KEY_LEFT)       key_dir = DIR_L;
    else if (bus.keycode == KEY_RIGHT) key_dir = DIR_R;
    else if (bus.keycode == KEY_DOWN)  key_dir = DIR_D;
    else if (bus.keycode == KEY_UP)    key_dir = DIR_U;
    else                               key_valid = 1'b0;
  end

  assign step = bus.speed_upgrade ? 11'(SPEED_FAST) : 11'(SPEED_SLOW);

  // Moves only ever happen along the held key, so the stepper always follows key_dir.
  tank_step_clamp u_step (
    .pos_x_i  (x_q),
    .pos_y_i  (y_q),
    .dir_i    (key_dir),
    .step_i   (step),
    .x_lo_i   (X_LO),
    .x_hi_i   (X_HI),
    .y_lo_i   (Y_LO),
    .y_hi_i   (Y_HI),
    .next_x_o (step_x),
    .next_y_o (step_y),
    .at_edge_o(at_edge)
  );

  // Barrier bit order differs from the direction encoding.
  always_comb begin
    bar_hit = 1'b0;
    unique case (key_dir)
      DIR_R: bar_hit = bus.barrier_collision[0];
      DIR_L: bar_hit = bus.barrier_collision[1];
      DIR_D: bar_hit = bus.barrier_collision[2];
      DIR_U: bar_hit = bus.barrier_collision[3];
    endcase
    blocked = bar_hit | at_edge;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    attempt = 1'b0;
`ifdef TANK_TURN_DELAY_EN
    cnt_d   = cnt_q;
`endif
    if (bus.spawn_req) begin
      state_d = ST_IDLE;
      x_d     = clamp_pos({1'b0, bus.spawn_x}, X_LO, X_HI);
      y_d     = clamp_pos({1'b0, bus.spawn_y}, Y_LO, Y_HI);
`ifdef TANK_TURN_DELAY_EN
      cnt_d   = '0;
`endif
    end else if (!key_valid) begin
      state_d = ST_IDLE;
`ifdef TANK_TURN_DELAY_EN
      cnt_d   = '0;
`endif
    end else begin
`ifdef TANK_TURN_DELAY_EN
      if (key_dir != dir_q) begin
        state_d = ST_TURN;
        dir_d   = key_dir;
        cnt_d   = TURN_LOAD;
      end else if (state_q == ST_TURN && cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        attempt = 1'b1;
      end
`else
      dir_d   = key_dir;
      attempt = 1'b1;
`endif
    end
    if (attempt) begin
      if (blocked) begin
        state_d = ST_BLOCKED;
      end else begin
        state_d = ST_MOVE;
        x_d     = step_x;
        y_d     = step_y;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_L;
      x_q      <= 10'(X_CENTER);
      y_q      <= 10'(Y_CENTER);
      moving_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef TANK_TURN_DELAY_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= (x_d != x_q) || (y_d != y_q);
      ack_q    <= bus.spawn_req;
`ifdef TANK_TURN_DELAY_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.BallX     = x_q;
  assign bus.BallY     = y_q;
  assign bus.BallS     = 10'(SIZE);
  assign bus.direction = dir_q;
  assign bus.moving    = moving_q;
  assign bus.spawn_ack = ack_q;
endmodule

// File: tb/tb_tank_mover.sv
// Bench for tank_mover: directed literal scenarios plus randomized frames scored against a behavioural model.
module tb_tank_mover;
  localparam int XL = 1 + 8;
  localparam int XH = 639 - 8;
  localparam int YL = 1 + 8;
  localparam int YH = 479 - 8;
  localparam int TURN_FRAMES = 4;
`ifdef TANK_TURN_DELAY_EN
  localparam bit DELAY = 1'b1;
`else
  localparam bit DELAY = 1'b0;
`endif

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  tank_mover_if bus();

  tank_mover dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_x, m_y, m_dir, m_wait;
  bit m_turning, m_ack, m_moving;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_to_dir(input logic [7:0] kc);
    case (kc)
      8'd80:   return 0;
      8'd79:   return 1;
      8'd81:   return 2;
      8'd82:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic try_move(input int k);
    int stp = bus.speed_upgrade ? 3 : 1;
    logic [3:0] bar = bus.barrier_collision;
    case (k)
      0: if (!bar[1] && m_x > XL) m_x = clampi(m_x - stp, XL, XH);
      1: if (!bar[0] && m_x < XH) m_x = clampi(m_x + stp, XL, XH);
      2: if (!bar[2] && m_y < YH) m_y = clampi(m_y + stp, YL, YH);
      3: if (!bar[3] && m_y > YL) m_y = clampi(m_y - stp, YL, YH);
      default: ;
    endcase
  endtask

  task automatic model_step();
    int k;
    int px = m_x;
    int py = m_y;
    if (Reset) begin
      m_x = 480; m_y = 240; m_dir = 0;
      m_turning = 0; m_wait = 0; m_ack = 0; m_moving = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_ack = bus.spawn_req;
      if (bus.spawn_req) begin
        m_x = clampi(int'(bus.spawn_x), XL, XH);
        m_y = clampi(int'(bus.spawn_y), YL, YH);
        m_turning = 0;
      end else begin
        k = key_to_dir(bus.keycode);
        if (k < 0) begin
          m_turning = 0;
        end else if (DELAY && k != m_dir) begin
          m_dir = k; m_turning = 1; m_wait = TURN_FRAMES - 1;
        end else if (m_turning && m_wait > 0) begin
          m_wait--;
        end else begin
          m_dir = k; m_turning = 0;
          try_move(k);
        end
      end
      m_moving = (m_x != px) || (m_y != py);
    end
  endtask

  // Scoreboard: advance the model on each edge, compare once the outputs have settled.
  always @(posedge frame_clk) begin
    model_step();
    #1;
    if (model_valid) begin
      chk("sb_BallX", int'(bus.BallX), m_x);
      chk("sb_BallY", int'(bus.BallY), m_y);
      chk("sb_BallS", int'(bus.BallS), 8);
      chk("sb_direction", int'(bus.direction), m_dir);
      chk("sb_moving", int'(bus.moving), int'(m_moving));
      chk("sb_spawn_ack", int'(bus.spawn_ack), int'(m_ack));
    end
  end

  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  logic [7:0] held_key;
  int yb;

  initial begin
    bus.keycode = 8'd0; bus.speed_upgrade = 1'b0; bus.barrier_collision = 4'b0;
    bus.spawn_req = 1'b1; bus.spawn_x = 10'd5; bus.spawn_y = 10'd5;
    Reset = 1'b1;
    frame(); frame();
    chk("rst_x", int'(bus.BallX), 480);
    chk("rst_y", int'(bus.BallY), 240);
    chk("rst_dir", int'(bus.direction), 0);
    chk("rst_ack", int'(bus.spawn_ack), 0);

    Reset = 1'b0; bus.spawn_req = 1'b0;
    repeat (10) frame();
    chk("idle_x", int'(bus.BallX), 480);
    chk("idle_y", int'(bus.BallY), 240);
    chk("idle_dir", int'(bus.direction), 0);
    chk("idle_moving", int'(bus.moving), 0);

    bus.keycode = 8'd79;
    for (int f = 1; f <= 6; f++) begin
      frame();
      chk("turn_dir", int'(bus.direction), 1);
      chk("turn_x", int'(bus.BallX),
          DELAY ? ((f <= TURN_FRAMES) ? 480 : 480 + f - TURN_FRAMES) : 480 + f);
    end

    bus.spawn_req = 1'b1; bus.spawn_x = 10'd2; bus.spawn_y = 10'd100;
    frame();
    chk("spawn_x", int'(bus.BallX), 9);
    chk("spawn_y", int'(bus.BallY), 100);
    chk("spawn_ack", int'(bus.spawn_ack), 1);
    chk("spawn_dir", int'(bus.direction), 1);
    bus.spawn_req = 1'b0; bus.keycode = 8'd0;
    frame();
    chk("spawn_ack_drop", int'(bus.spawn_ack), 0);
    chk("spawn_x_hold", int'(bus.BallX), 9);

    bus.spawn_req = 1'b1; bus.spawn_x = 10'd628; bus.spawn_y = 10'd240;
    frame();
    chk("edge_spawn_x", int'(bus.BallX), 628);
    bus.spawn_req = 1'b0; bus.keycode = 8'd79; bus.speed_upgrade = 1'b1;
    frame();
    chk("edge_step_x", int'(bus.BallX), 631);
    chk("edge_step_moving", int'(bus.moving), 1);
    repeat (2) begin
      frame();
      chk("edge_hold_x", int'(bus.BallX), 631);
      chk("edge_hold_moving", int'(bus.moving), 0);
    end

    bus.keycode = 8'd82; bus.speed_upgrade = 1'b0;
    repeat (8) frame();
    yb = DELAY ? 240 - (8 - TURN_FRAMES) : 240 - 8;
    chk("up_y", int'(bus.BallY), yb);
    chk("up_dir", int'(bus.direction), 3);
    bus.barrier_collision = 4'b1000;
    repeat (5) begin
      frame();
      chk("bar_y", int'(bus.BallY), yb);
      chk("bar_moving", int'(bus.moving), 0);
    end
    bus.barrier_collision = 4'b0000;
    frame();
    chk("bar_clear_y", int'(bus.BallY), yb - 1);
    chk("bar_clear_moving", int'(bus.moving), 1);

    bus.keycode = 8'd81;
    frame();
    chk("pre_rst_dir", int'(bus.direction), 2);
    Reset = 1'b1; bus.spawn_req = 1'b1; bus.spawn_x = 10'd2; bus.spawn_y = 10'd2;
    frame();
    chk("mid_rst_x", int'(bus.BallX), 480);
    chk("mid_rst_y", int'(bus.BallY), 240);
    chk("mid_rst_dir", int'(bus.direction), 0);
    chk("mid_rst_ack", int'(bus.spawn_ack), 0);
    chk("mid_rst_moving", int'(bus.moving), 0);
    Reset = 1'b0; bus.spawn_req = 1'b0; bus.keycode = 8'd0;
    frame();

    held_key = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 5))
          0: held_key = 8'd80;
          1: held_key = 8'd79;
          2: held_key = 8'd81;
          3: held_key = 8'd82;
          4: held_key = 8'd0;
          default: held_key = 8'($urandom);
        endcase
      end
      bus.keycode           = held_key;
      Reset                 = ($urandom_range(0, 299) == 0);
      bus.spawn_req         = ($urandom_range(0, 39) == 0);
      bus.spawn_x           = 10'($urandom_range(0, 1023));
      bus.spawn_y           = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) bus.speed_upgrade = ~bus.speed_upgrade;
      bus.barrier_collision = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tank_mover.md
TANK_MOVER -- requirements
Module: tank_mover

Interface
REQ-001 SHALL have parameter X_CENTER, 480, reset/spawn default X.
REQ-002 SHALL have parameter Y_CENTER, 240, reset/spawn default Y.
REQ-003 SHALL have parameters X_MIN/X_MAX/Y_MIN/Y_MAX, 1/639/1/479, arena bounds.
REQ-004 SHALL have parameter SIZE, 8, tank half-extent in pixels.
REQ-005 SHALL have parameters SPEED_SLOW/SPEED_FAST, 1/3, pixels per frame.
REQ-006 SHALL have parameter TURN_FRAMES, 4, frames spent rotating before moving (1..15).
REQ-007 SHALL have parameters KEY_LEFT/KEY_RIGHT/KEY_DOWN/KEY_UP, 80/79/81/82, keycodes.
REQ-008 SHALL have ports: frame_clk  in  1  sole clock; Reset  in  1  synchronous active-high reset.
REQ-009 SHALL have ports: keycode  in  8  held key; speed_upgrade  in  1  select SPEED_FAST.
REQ-010 SHALL have port barrier_collision  in  4  bit0 right blocked, bit1 left, bit2 down, bit3 up.
REQ-011 SHALL have ports spawn_req  in  1, spawn_x  in  10, spawn_y  in  10: respawn request and target.
REQ-012 SHALL have ports BallX, BallY, BallS  out  10: centre X, centre Y, SIZE.
REQ-013 SHALL have ports direction  out  2 (00 L, 01 R, 10 D, 11 U); moving  out  1; spawn_ack  out  1.

Function
REQ-014 SHALL implement FSM IDLE, TURN, MOVE, BLOCKED, registered on frame_clk.
REQ-015 IDLE: no mapped key -> remain; mapped key equal to direction -> MOVE or BLOCKED per REQ-018; key differing -> TURN.
REQ-016 TURN: direction updates to the key's code on entry; counter counts TURN_FRAMES frames, then -> MOVE/BLOCKED; a different key restarts the count; key release -> IDLE.
REQ-017 MOVE: each frame, position steps by SPEED_FAST when speed_upgrade is high, else SPEED_SLOW, with the same-frame keycode (no motion-register lag).
REQ-018 BLOCKED entered when the barrier_collision bit for direction is set or the tank already touches the edge; position holds; leaves when the bit clears (-> MOVE) or key changes/releases.
REQ-019 Edge clamp: computed in 11-bit unsigned; X limited to [X_MIN+SIZE, X_MAX-SIZE], Y to [Y_MIN+SIZE, Y_MAX-SIZE]; a step SHALL never overshoot or wrap.
REQ-020 Unmapped keycodes SHALL behave as release.
REQ-021 moving SHALL be 1 exactly in frames where position changed.
REQ-022 spawn_req SHALL have priority over all keys: next frame position = clamped spawn_x/spawn_y, state IDLE, direction unchanged, spawn_ack pulses 1 for one frame.
REQ-023 spawn_req held SHALL re-ack each frame; keys ignored while held.
REQ-024 BallS SHALL be constant SIZE.

Reset
REQ-025 On Reset high at a frame_clk edge: BallX=X_CENTER, BallY=Y_CENTER, direction=00, state IDLE, counter 0, moving=0, spawn_ack=0.
REQ-026 Reset SHALL override spawn_req and abort TURN/MOVE mid-operation.

Configuration
REQ-027 Macro TANK_TURN_DELAY_EN defined: TURN behaves per REQ-016.
REQ-028 Macro absent: TURN state and counter are not built; direction change takes effect and moves in the same frame; TURN_FRAMES ignored.

Structure
REQ-029 Package tank_pkg SHALL hold dir_t (DIR_L/R/D/U), tank_state_t enum, and default keycode constants.
REQ-030 Sub-module tank_step_clamp (combinational: pos, dir, step, bounds -> next pos, at_edge) SHALL be instantiated once.

Verification
REQ-031 Reset, then keycode=0 for 10 frames -> BallX=480, BallY=240, direction=00, moving=0.
REQ-032 TURN_DELAY_EN, hold 79 -> direction=01 at frame 1, BallX still 480 through frame 4, then 481, 482 per frame.
REQ-033 BallX=628, speed_upgrade=1, hold 79 -> 631, then holds at 631 (639-8), state BLOCKED, moving=0.
REQ-034 Move up, barrier_collision[3]=1 for 5 frames -> Y frozen, BLOCKED; clear bit -> Y decrements next frame.
REQ-035 spawn_req with spawn_x=2, spawn_y=100 while moving -> next frame BallX=9, BallY=100, spawn_ack=1 one frame, IDLE.
REQ-036 Reset asserted mid-TURN with spawn_req=1 -> centre position, direction=00, spawn_ack=0.
